// File: rtl/esp_frame_tx.sv
// esp_frame_tx: FIFO-buffered serialiser for the 2-wire (SCLK + IO_SPI) ESP8266 link.
// Each frame carries a start bit and DATA_W bits MSB-first, followed by an idle gap.
//
// state   | meaning
// S_IDLE  | waiting for a word in the FIFO
// S_LOAD  | pop head word into the shifter (one cycle)
// S_SHIFT | drive start bit + payload, one bit per 2*CLK_DIV cycles
// S_GAP   | link idle for GAP_BITS bit periods, done on the last cycle
module esp_frame_tx #(
  parameter int CLK_DIV    = 50,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 2
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          SCLK,
  output logic                          IO_SPI,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DIV_W   = $clog2(2 * CLK_DIV);
  localparam int BIT_W   = $clog2(DATA_W + 2);
  localparam int GAP_LEN = GAP_BITS * 2 * CLK_DIV;
  localparam int GAP_W   = $clog2(GAP_LEN + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W:0]     shift_q, shift_d;
  logic                sclk_q, sclk_d;
  logic                io_q, io_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push, pop;

  // Ready comes only from the registered count: a pop in the same cycle never frees a slot.
  assign wr_ready   = (cnt_q < CNT_FULL);
  assign push       = wr_valid && wr_ready;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
  assign SCLK       = sclk_q;
  assign IO_SPI     = io_q;
  assign done       = done_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop     = 1'b1;
        shift_d = {1'b1, mem[rd_ptr_q]};
        bit_d   = '0;
        div_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          // Rotating is equivalent to shifting: the wrapped bit is never driven out.
          shift_d = {shift_q[DATA_W-1:0], shift_q[DATA_W]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the pins are plain flops.
  always_comb begin
    sclk_d = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
    io_d   = (state_d == S_SHIFT) && shift_d[DATA_W];
    done_d = (state_d == S_GAP) && (gap_d == '0);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shift_q  <= '0;
      sclk_q   <= 1'b0;
      io_q     <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      io_q     <= io_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
